// File: rtl/lock_pkg.sv
// Shared types and default timing constants for the door lock controller
// and for the logic that reports its status.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED     = 2'd0,
    RELEASED   = 2'd1,
    WAIT_CLOSE = 2'd2,
    ALARM      = 2'd3
  } lock_state_t;

  localparam int DEF_OPEN_CYCLES = 8;
  localparam int DEF_HOLD_LIMIT  = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that saturates at a run-time terminal value; tc flags that the
// terminal value has been reached.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != term)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/door_lock_ctrl.sv
// Door bolt controller: energises the relay for a fixed window after each
// unlock pulse, waits for the door to shut, and latches an alarm on abuse.
module door_lock_ctrl
  import lock_pkg::*;
#(
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  parameter int HOLD_LIMIT  = DEF_HOLD_LIMIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       unlock,
  input  logic       door_closed,
  input  logic       alarm_clr,
  output logic       relay,
  output logic       alarm,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(max_int(OPEN_CYCLES, HOLD_LIMIT));
  localparam logic [CW-1:0] OPEN_TERM = CW'(OPEN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TERM = CW'(HOLD_LIMIT - 1);

  lock_state_t   state_q, state_d;
  logic          relay_q, relay_d;
  logic          alarm_q, alarm_d;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [CW-1:0] tmr_term;

  assign tmr_term = (state_q == WAIT_CLOSE) ? HOLD_TERM : OPEN_TERM;

  cycle_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .tc      (tmr_tc)
  );

  // Timer is held cleared everywhere except while a window is running.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    case (state_q)
      LOCKED: begin
        if (unlock)            state_d = RELEASED;
        else if (!door_closed) state_d = ALARM;
      end
      RELEASED: begin
        if (unlock) begin
          state_d = RELEASED;
        end else if (tmr_tc) begin
          state_d = door_closed ? LOCKED : WAIT_CLOSE;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      WAIT_CLOSE: begin
        if (unlock)           state_d = RELEASED;
        else if (door_closed) state_d = LOCKED;
        else if (tmr_tc)      state_d = ALARM;
        else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      ALARM: begin
        if (alarm_clr && door_closed) state_d = LOCKED;
      end
      default: state_d = LOCKED;
    endcase
    relay_d = (state_d == RELEASED);
    alarm_d = (state_d == ALARM);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOCKED;
      relay_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      relay_q <= relay_d;
      alarm_q <= alarm_d;
    end
  end

  assign relay   = relay_q;
  assign alarm   = alarm_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl: a reference model queues the expected
// outputs for each cycle and they are compared once the DUT has clocked.
module tb_door_lock_ctrl;
  import lock_pkg::*;

  localparam int OPEN_C = 8;
  localparam int HOLD_C = 16;

  logic       clk = 1'b0;
  logic       reset_n, unlock, door_closed, alarm_clr;
  logic       relay, alarm;
  logic [1:0] state_o;

  door_lock_ctrl #(.OPEN_CYCLES(OPEN_C), .HOLD_LIMIT(HOLD_C)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .unlock      (unlock),
    .door_closed (door_closed),
    .alarm_clr   (alarm_clr),
    .relay       (relay),
    .alarm       (alarm),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       relay;
    logic       alarm;
    logic [1:0] st;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  lock_state_t m_st = LOCKED;
  int          m_cnt = 0;
  int          cyc = 0;
  int          relay_hi = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  logic        prev_relay = 1'b0;
  logic        prev_alarm = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Reference behaviour taken from the state descriptions, one edge at a time.
  task automatic model_edge(input logic u, input logic dc, input logic ac, input logic rn);
    if (!rn) begin
      m_st = LOCKED; m_cnt = 0;
    end else begin
      case (m_st)
        LOCKED: begin
          if (u) begin m_st = RELEASED; m_cnt = 0; end
          else if (!dc) m_st = ALARM;
        end
        RELEASED: begin
          if (u) m_cnt = 0;
          else if (m_cnt == OPEN_C - 1) begin
            m_st = dc ? LOCKED : WAIT_CLOSE; m_cnt = 0;
          end else m_cnt++;
        end
        WAIT_CLOSE: begin
          if (u) begin m_st = RELEASED; m_cnt = 0; end
          else if (dc) begin m_st = LOCKED; m_cnt = 0; end
          else if (m_cnt == HOLD_C - 1) begin m_st = ALARM; m_cnt = 0; end
          else m_cnt++;
        end
        default: if (ac && dc) m_st = LOCKED;
      endcase
    end
  endtask

  task automatic step(input logic u, input logic dc, input logic ac, input logic rn, input string tag);
    exp_t e;
    unlock = u; door_closed = dc; alarm_clr = ac; reset_n = rn;
    model_edge(u, dc, ac, rn);
    e.relay = (m_st == RELEASED);
    e.alarm = (m_st == ALARM);
    e.st    = m_st;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    chk({tag, ".relay"}, int'(relay), int'(e.relay));
    chk({tag, ".alarm"}, int'(alarm), int'(e.alarm));
    chk({tag, ".state"}, int'(state_o), int'(e.st));
    if (relay) relay_hi++;
    if (prev_relay && !relay) fall_cyc = cyc;
    if (!prev_alarm && alarm) rise_cyc = cyc;
    prev_relay = relay;
    prev_alarm = alarm;
  endtask

  initial begin
    unlock = 1'b0; door_closed = 1'b1; alarm_clr = 1'b0; reset_n = 1'b0;

    step(0, 1, 0, 0, "reset0");
    step(0, 1, 0, 0, "reset1");
    chk("reset_state", int'(state_o), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "idle");

    // Normal entry with the door briefly open during the window
    relay_hi = 0;
    step(1, 1, 0, 1, "norm_unlock");
    step(0, 1, 0, 1, "norm");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "norm_open");
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, "norm");
    chk("norm_relay_len", relay_hi, OPEN_C);
    chk("norm_end_state", int'(state_o), int'(LOCKED));

    // Retrigger five cycles into the window
    relay_hi = 0;
    step(1, 1, 0, 1, "retrig_u1");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, "retrig");
    step(1, 1, 0, 1, "retrig_u2");
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, "retrig");
    chk("retrig_relay_len", relay_hi, 5 + OPEN_C);

    // Door held open after the relay drops
    step(1, 1, 0, 1, "hold_unlock");
    step(0, 1, 0, 1, "hold");
    for (int i = 0; i < 40 && !alarm; i++) step(0, 0, 0, 1, "hold_open");
    chk("hold_alarm_set", int'(alarm), 1);
    chk("hold_gap", rise_cyc - fall_cyc, HOLD_C);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, "hold_clr_open");
    chk("clr_door_open", int'(alarm), 1);
    step(0, 1, 1, 1, "hold_clr_closed");
    chk("clr_door_closed", int'(state_o), int'(LOCKED));

    // Forced entry, then an unlock that must be ignored
    step(0, 0, 0, 1, "forced");
    chk("forced_alarm", int'(alarm), 1);
    step(1, 0, 0, 1, "forced_unlock");
    chk("forced_no_relay", int'(relay), 0);
    step(0, 1, 0, 1, "forced_closed_noclr");
    step(0, 1, 1, 1, "forced_clear");

    // Simultaneous unlock and door open in LOCKED, then unlock+close in WAIT_CLOSE
    step(1, 0, 0, 1, "simul_locked");
    chk("simul_locked_state", int'(state_o), int'(RELEASED));
    for (int i = 0; i < OPEN_C; i++) step(0, 0, 0, 1, "simul_win");
    chk("simul_wait_state", int'(state_o), int'(WAIT_CLOSE));
    step(1, 1, 0, 1, "simul_wait");
    chk("simul_wait_rel", int'(state_o), int'(RELEASED));
    for (int i = 0; i < OPEN_C; i++) step(0, 1, 0, 1, "simul_tail");

    // Reset mid-window, then a full fresh window
    step(1, 1, 0, 1, "mid_unlock");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "mid");
    step(0, 1, 0, 0, "mid_reset");
    chk("mid_reset_relay", int'(relay), 0);
    relay_hi = 0;
    step(1, 1, 0, 1, "mid_unlock2");
    for (int i = 0; i < OPEN_C + 1; i++) step(0, 1, 0, 1, "mid_tail");
    chk("mid_relay_len", relay_hi, OPEN_C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
